// File: rtl/latch_pkg.sv
// Shared types and helpers for the latch sequencing bank.
package latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // Bits needed to hold OPEN_CYCLES-1 (at least one bit).
  function automatic int cnt_width(input int open_cycles);
    return (open_cycles <= 1) ? 1 : $clog2(open_cycles);
  endfunction

endpackage

// File: rtl/latch_cell.sv
// One channel of level-sensitive storage: async clear, transparent on le or bypass,
// with bypass data taking priority over the registered write data.
module latch_cell #(
  parameter int WIDTH = 8
) (
  input  logic             i_clr_n,
  input  logic             i_le,
  input  logic             i_bypass,
  input  logic [WIDTH-1:0] i_byp_data,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_q
);

  logic             w_en;
  logic [WIDTH-1:0] w_d;

  assign w_en = i_le | i_bypass;
  assign w_d  = i_bypass ? i_byp_data : i_wr_data;

  always_latch begin
    if (!i_clr_n)  o_q <= '0;
    else if (w_en) o_q <= w_d;
  end

endmodule

// File: rtl/latch_seq_bank.sv
// Write sequencer for a bank of latches.  IDLE: ready for a write | OPEN: le[chan]
// high for OPEN_CYCLES cycles | GUARD: one cycle with le low so data outlasts the enable.
module latch_seq_bank
  import latch_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int OPEN_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [$clog2(CHANNELS)-1:0] wr_chan,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [CHANNELS-1:0]         bypass,
  input  logic [WIDTH-1:0]            byp_data,
  output logic [CHANNELS*WIDTH-1:0]   q,
  output logic [CHANNELS-1:0]         le,
  output logic                        busy
);

  localparam int CHAN_W = $clog2(CHANNELS);
  localparam int CNT_W  = cnt_width(OPEN_CYCLES);

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CHANNELS-1:0] r_le;
  logic [WIDTH-1:0]    r_data;
  logic                r_wr_ready;
  logic [1:0]          r_rst_sync;
  logic                w_rst_sync_n;
  logic [CHANNELS-1:0] w_le_dec;

  // Reset asserts at once but releases the FSM only after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_sync_n = r_rst_sync[1];

  // Out-of-range channels decode to all-zero, so the write runs but touches nothing.
  always_comb begin
    w_le_dec = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_chan == CHAN_W'(k)) w_le_dec[k] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_le       <= '0;
      r_data     <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wr_valid && r_wr_ready) begin
            r_state    <= ST_OPEN;
            r_cnt      <= CNT_W'(OPEN_CYCLES - 1);
            r_data     <= wr_data;
            r_le       <= w_le_dec;
            r_wr_ready <= 1'b0;
          end else begin
            r_wr_ready <= 1'b1;
          end
        end
        ST_OPEN: begin
          if (r_cnt == '0) begin
            r_state <= ST_GUARD;
            r_le    <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_GUARD: begin
          r_state    <= ST_IDLE;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_le    <= '0;
        end
      endcase
    end
  end

  assign wr_ready = r_wr_ready;
  assign le       = r_le;
  assign busy     = (r_state != ST_IDLE);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_cell
    latch_cell #(.WIDTH(WIDTH)) u_cell (
      .i_clr_n    (rst_n),
      .i_le       (r_le[k]),
      .i_bypass   (bypass[k]),
      .i_byp_data (byp_data),
      .i_wr_data  (r_data),
      .o_q        (q[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_latch_seq_bank.sv
// Scoreboard bench for latch_seq_bank: writes push the expected channel value, and the
// monitor pops and compares it when the enable rises; a second instance covers bad channels.
module tb_latch_seq_bank;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int OC = 2;
  localparam int BCH = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0]      wr_chan = '0;
  logic [W-1:0]    wr_data = '0;
  logic [CH-1:0]   bypass = '0;
  logic [W-1:0]    byp_data = '0;
  logic [CH*W-1:0] q;
  logic [CH-1:0]   le;
  logic            busy;

  logic             b_wr_valid = 1'b0;
  logic             b_wr_ready;
  logic [2:0]       b_wr_chan = '0;
  logic [W-1:0]     b_wr_data = '0;
  logic [BCH-1:0]   b_bypass = '0;
  logic [W-1:0]     b_byp_data = '0;
  logic [BCH*W-1:0] b_q;
  logic [BCH-1:0]   b_le;
  logic             b_busy;

  always #5 clk = ~clk;

  latch_seq_bank #(.WIDTH(W), .CHANNELS(CH), .OPEN_CYCLES(OC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_data(wr_data), .bypass(bypass), .byp_data(byp_data),
    .q(q), .le(le), .busy(busy)
  );

  latch_seq_bank #(.WIDTH(W), .CHANNELS(BCH), .OPEN_CYCLES(OC)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_chan(b_wr_chan), .wr_data(b_wr_data), .bypass(b_bypass), .byp_data(b_byp_data),
    .q(b_q), .le(b_le), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int           chan;
    logic [W-1:0] val;
    time          t_acc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  bit            abort_cnt = 1'b0;
  int            le_hi = 0;
  logic [CH-1:0] le_prev = '0;
  time           last_acc;

  function automatic logic [W-1:0] qch(input int k);
    return q[k*W +: W];
  endfunction

  always @(negedge clk) begin
    if (le != '0 && le_prev == '0) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("le_onehot", 64'(le), 64'(1) << mon_e.chan);
        check_eq("q_on_open", 64'(qch(mon_e.chan)), 64'(mon_e.val));
        check_eq("write_latency", 64'($time - mon_e.t_acc), 64'd5);
      end
      le_hi = 1;
    end else if (le != '0) begin
      le_hi++;
    end else if (le_prev != '0) begin
      if (!abort_cnt) check_eq("le_width", 64'(le_hi), 64'(OC));
      le_hi = 0;
    end
    le_prev = le;
  end

  task automatic do_write(input int chan, input logic [W-1:0] data,
                          input logic [W-1:0] expv, input bit keep_valid);
    int budget;
    budget   = 0;
    wr_chan  = chan[1:0];
    wr_data  = data;
    wr_valid = 1'b1;
    while (!wr_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!wr_ready) begin
      check_eq("ready_timeout", 64'd0, 64'd1);
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_acc = $time;
    sb.push_back('{chan, expv, $time});
    @(negedge clk);
    if (!keep_valid) wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || !wr_ready) && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (busy || !wr_ready) check_eq("idle_timeout", 64'({busy, wr_ready}), 64'b01);
  endtask

  task automatic b_write(input logic [2:0] chan, input logic [W-1:0] data);
    int budget;
    budget     = 0;
    b_wr_chan  = chan;
    b_wr_data  = data;
    b_wr_valid = 1'b1;
    while (!b_wr_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!b_wr_ready) check_eq("b_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    b_wr_valid = 1'b0;
  endtask

  initial begin
    time          t_acc[3];
    logic [BCH*W-1:0] bq_exp;
    int           oor[2];
    oor = '{5, 7};

    // reset, with bypass asserted to show clear wins
    #1 rst_n = 1'b0;
    #2 bypass = '1; byp_data = 8'hFF;
    #9;
    check_eq("rst_q", 64'(q), 64'd0);
    check_eq("rst_le", 64'(le), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    bypass = '0; byp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

    // single write, chan 2
    @(negedge clk);
    do_write(2, 8'hA5, 8'hA5, 1'b0);
    check_eq("w1_busy_c1", 64'(busy), 64'd1);
    check_eq("w1_ready_c1", 64'(wr_ready), 64'd0);
    @(negedge clk);
    check_eq("w1_busy_c2", 64'(busy), 64'd1);
    check_eq("w1_le_c2", 64'(le), 64'b0100);
    @(negedge clk);
    check_eq("w1_guard_busy", 64'(busy), 64'd1);
    check_eq("w1_guard_le", 64'(le), 64'd0);
    @(negedge clk);
    check_eq("w1_done_busy", 64'(busy), 64'd0);
    check_eq("w1_done_ready", 64'(wr_ready), 64'd1);
    check_eq("w1_q", 64'(q), 64'h00A5_0000);

    // back-to-back with wr_valid held: chans 0, 1, 0
    @(negedge clk);
    do_write(0, 8'h11, 8'h11, 1'b1); t_acc[0] = last_acc;
    do_write(1, 8'h22, 8'h22, 1'b1); t_acc[1] = last_acc;
    do_write(0, 8'h33, 8'h33, 1'b0); t_acc[2] = last_acc;
    check_eq("b2b_gap01", 64'(t_acc[1] - t_acc[0]), 64'd40);
    check_eq("b2b_gap12", 64'(t_acc[2] - t_acc[1]), 64'd40);
    wait_idle();
    check_eq("b2b_q", 64'(q), 64'h00A5_2233);

    // write chan 0 under bypass: bypass wins and the write is lost
    @(negedge clk);
    byp_data = 8'h5A; bypass[0] = 1'b1;
    do_write(0, 8'hC3, 8'h5A, 1'b0);
    wait_idle();
    check_eq("byp_win_q0", 64'(qch(0)), 64'h5A);
    bypass[0] = 1'b0;
    #1 byp_data = 8'h99;
    #1 check_eq("byp_hold_q0", 64'(qch(0)), 64'h5A);

    // bypass drops while le is high: channel follows registered data
    @(negedge clk);
    byp_data = 8'h11; bypass[2] = 1'b1;
    do_write(2, 8'h77, 8'h11, 1'b0);
    #1 bypass[2] = 1'b0;
    #1 check_eq("byp_fall_q2", 64'(qch(2)), 64'h77);
    wait_idle();
    check_eq("byp_fall_hold_q2", 64'(qch(2)), 64'h77);

    // transparent sweep on chan 1
    @(negedge clk);
    bypass[1] = 1'b1;
    for (int v = 0; v < 256; v++) begin
      byp_data = W'(v);
      #1;
      if (qch(1) !== W'(v)) check_eq("sweep_q1", 64'(qch(1)), 64'(v));
      else n_checks++;
    end
    bypass[1] = 1'b0;
    #1 byp_data = 8'h12;
    #1 check_eq("sweep_hold_q", 64'(q), 64'h0077_FF5A);

    // out-of-range channel on a 5-channel bank
    @(negedge clk);
    b_write(3'd2, 8'h42);
    bq_exp = '0;
    bq_exp[2*W +: W] = 8'h42;
    check_eq("b_q_init", 64'(b_q), 64'(bq_exp));
    for (int i = 0; i < 2; i++) begin
      while (!b_wr_ready) @(negedge clk);
      b_write(3'(oor[i]), 8'hEE);
      for (int c = 0; c < 3; c++) begin
        check_eq("oor_busy", 64'(b_busy), 64'd1);
        check_eq("oor_le", 64'(b_le), 64'd0);
        @(negedge clk);
      end
      check_eq("oor_done_busy", 64'(b_busy), 64'd0);
      check_eq("oor_q", 64'(b_q), 64'(bq_exp));
    end

    // reset pulse mid-OPEN on chan 3
    @(negedge clk);
    do_write(3, 8'h3C, 8'h3C, 1'b0);
    #2 abort_cnt = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_q", 64'(q), 64'd0);
    check_eq("abort_le", 64'(le), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);
    abort_cnt = 1'b0;
    check_eq("abort_ready", 64'(wr_ready), 64'd1);
    check_eq("abort_no_late_q", 64'(q), 64'd0);
    check_eq("abort_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
